seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL provide parameter DATA_W, default 16, width of value; legal range 4..27.
REQ-003 SHALL provide parameter REFRESH_DIV, default 262144, clock cycles each digit stays active; legal minimum 2.
REQ-004 SHALL provide port clock_100Mhz, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL provide port value, input, DATA_W, unsigned number to display; sampled only on an accepted load.
REQ-007 SHALL provide port load, input, 1, single-cycle capture strobe.
REQ-008 SHALL provide port mode, input, 1, format of the captured value: 0 = hex, 1 = decimal; sampled with load.
REQ-009 SHALL provide port blank_lz, input, 1, leading-zero blanking enable; sampled live.
REQ-010 SHALL provide port dp_mask, input, NUM_DIGITS, decimal point enable per digit; sampled live.
REQ-011 SHALL provide port anode_n, output, NUM_DIGITS, digit enables, active-low; bit 0 = rightmost digit.
REQ-012 SHALL provide port seg_n, output, 7, segments a..g on bits 6..0, active-low.
REQ-013 SHALL provide port dp_n, output, 1, decimal point, active-low.
REQ-014 SHALL provide port busy, output, 1, high while a decimal conversion is in progress.
REQ-015 SHALL provide port overflow, output, 1, high while the displayed value does not fit NUM_DIGITS digits.

Function
REQ-016 Scan: SHALL keep a prescaler that counts 0..REFRESH_DIV-1 and a digit index 0..NUM_DIGITS-1; the index advances when the prescaler wraps, and advances from NUM_DIGITS-1 back to 0.
REQ-017 anode_n, seg_n and dp_n SHALL be registered with 1 cycle latency from the digit index; exactly one anode_n bit SHALL be low outside reset.
REQ-018 Encoding SHALL follow this table (abcdefg, 1 = off):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- blank=1111111, dash=1111110
REQ-019 dp_n SHALL equal ~dp_mask[active digit].
REQ-020 Capture SHALL happen only when load=1 and the FSM is in IDLE; a load in any other state SHALL be ignored.
REQ-021 Hex mode SHALL update the display registers on the edge that samples load, with digit k = value[4k+3:4k], zero-extended.
REQ-022 In hex mode, overflow SHALL be set if any value bit at or above position 4*NUM_DIGITS is 1.
REQ-023 The FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on an accepted decimal load.
- SHIFT performs one double-dabble step per cycle (add 3 to each BCD nibble >= 5, then shift left one bit) for exactly DATA_W cycles, then goes to DONE.
- DONE commits the result to the display registers and returns to IDLE.
REQ-024 busy SHALL be high in SHIFT and DONE, i.e. DATA_W+1 cycles starting the cycle after load; the display SHALL change atomically on the DONE->IDLE edge.
REQ-025 In decimal mode, overflow SHALL be set if value > 10^NUM_DIGITS - 1; an overflowed value SHALL display dash on all digits, still with DATA_W+1 cycle busy timing.
REQ-026 The display registers, digit values and overflow SHALL hold until the next commit.
REQ-027 Leading-zero blanking: when blank_lz=1, every zero digit above the most significant nonzero digit SHALL be blank; digit 0 SHALL never be blanked; blanking SHALL not apply while overflow=1.
REQ-028 The scan SHALL run continuously and independently of load and busy.

Reset
REQ-029 Reset SHALL force the following values, including mid-conversion:
- anode_n all ones, seg_n 1111111, dp_n 1, busy 0, overflow 0;
- display digits all zero, prescaler 0, digit index 0, FSM IDLE.
REQ-030 A conversion interrupted by reset SHALL be discarded with no commit.
REQ-031 After reset release, digit 0 SHALL be driven on the first active edge.

Verification (NUM_DIGITS=4, DATA_W=16, REFRESH_DIV=4)
REQ-032 Reset then idle 40 cycles -> anode_n cycles 1110, 1101, 1011, 0111, 1110, 4 cycles each; seg_n=0000001 on every digit.
REQ-033 Hex load 0xBEEF -> next cycle digits 3..0 show 1100000, 0110000, 0110000, 0111000; busy never asserts.
REQ-034 Decimal load 1234 -> busy high for 17 cycles; then digits show 1, 2, 3, 4; overflow 0.
REQ-035 Decimal load 42 with blank_lz=1 -> digits 3 and 2 show 1111111, digit 1 shows 4, digit 0 shows 2; load 0 -> only digit 0 lit, showing 0.
REQ-036 Decimal load 12345 -> overflow=1 and all digits show 1111110.
REQ-037 A second load during busy is ignored (result equals the first value), and reset asserted mid-SHIFT keeps the previous display zero; dp_mask=0100 -> dp_n low only while anode_n=1011.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment driver: hex/decimal capture, double-dabble conversion, digit scan.
// Outputs are registered one cycle after the digit index; a decimal load is busy for DATA_W+1 cycles.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 262144
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  busy,
    output logic                  overflow
);
    localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(DATA_W);
    // Every 3 binary bits need less than one decimal digit, so this bounds the BCD width.
    localparam int BCD_N  = (DATA_W + 2) / 3;
    localparam int BCD_W  = 4 * BCD_N;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int SR_W   = BCD_W + DATA_W;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SR_W-1:0]       sr_q, sr_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;

    logic [DISP_W+DATA_W-1:0] val_ext;
    logic [DISP_W+BCD_W-1:0]  bcd_ext;
    logic [SR_W-1:0]          dd_adj;
    logic [SR_W-1:0]          dd_step;
    logic [NUM_DIGITS-1:0]    lz_v;
    logic                     lz_allz;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'h0: seg_enc = 7'b0000001;
            4'h1: seg_enc = 7'b1001111;
            4'h2: seg_enc = 7'b0010010;
            4'h3: seg_enc = 7'b0000110;
            4'h4: seg_enc = 7'b1001100;
            4'h5: seg_enc = 7'b0100100;
            4'h6: seg_enc = 7'b0100000;
            4'h7: seg_enc = 7'b0001111;
            4'h8: seg_enc = 7'b0000000;
            4'h9: seg_enc = 7'b0000100;
            4'hA: seg_enc = 7'b0001000;
            4'hB: seg_enc = 7'b1100000;
            4'hC: seg_enc = 7'b0110001;
            4'hD: seg_enc = 7'b1000010;
            4'hE: seg_enc = 7'b0110000;
            default: seg_enc = 7'b0111000;
        endcase
    endfunction

    // Zero-extended views so digits/overflow fall out of plain slices for any parameter mix.
    assign val_ext = {{DISP_W{1'b0}}, value};
    assign bcd_ext = {{DISP_W{1'b0}}, sr_q[SR_W-1 -: BCD_W]};

    always_comb begin
        dd_adj = sr_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (dd_adj[DATA_W+4*i +: 4] >= 4'd5)
                dd_adj[DATA_W+4*i +: 4] = dd_adj[DATA_W+4*i +: 4] + 4'd3;
        end
        dd_step = dd_adj << 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (mode) begin
                        sr_d    = {{BCD_W{1'b0}}, value};
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        disp_d = val_ext[DISP_W-1:0];
                        ovf_d  = |val_ext[DISP_W+DATA_W-1:DISP_W];
                    end
                end
            end
            SHIFT: begin
                sr_d  = dd_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = DONE;
            end
            DONE: begin
                disp_d  = bcd_ext[DISP_W-1:0];
                ovf_d   = |bcd_ext[DISP_W+BCD_W-1:DISP_W];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // lz_v[k] marks digit k as a leading zero: it and every digit above it are zero.
    always_comb begin
        lz_v    = '0;
        lz_allz = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_allz = lz_allz & (disp_q[4*k +: 4] == 4'd0);
            lz_v[k] = lz_allz;
        end
    end

    always_comb begin
        anode_n_d = ~(NUM_DIGITS'(1) << idx_q);
        dp_n_d    = ~dp_mask[idx_q];
        if (ovf_q)
            seg_n_d = SEG_DASH;
        else if (blank_lz && lz_v[idx_q])
            seg_n_d = SEG_BLANK;
        else
            seg_n_d = seg_enc(disp_q[idx_q*4 +: 4]);
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            anode_n_q <= '1;
            seg_n_q   <= SEG_BLANK;
            dp_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            anode_n_q <= anode_n_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign anode_n  = anode_n_q;
    assign seg_n    = seg_n_q;
    assign dp_n     = dp_n_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, 16-bit value and a 4-cycle refresh.
module tb_seven_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    logic       busy_seen;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, SB = 7'b1100000, SE = 7'b0110000, SF = 7'b0111000;
    localparam logic [6:0] SBLK = 7'b1111111, SDASH = 7'b1111110;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4)) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .value       (value),
        .load        (load),
        .mode        (mode),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .anode_n     (anode_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic m);
        @(posedge clk);
        #1 value = v; mode = m; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Watches one full scan (plus margin) and records segments/dp seen under each anode.
    task automatic capture();
        logic [3:0] onehot;
        for (int d = 0; d < 4; d++) begin
            cap_seg[d] = 'x;
            cap_dp[d]  = 1'bx;
        end
        busy_seen = 1'b0;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            for (int d = 0; d < 4; d++) begin
                onehot = 4'b0001 << d;
                if (anode_n === ~onehot) begin
                    cap_seg[d] = seg_n;
                    cap_dp[d]  = dp_n;
                end
            end
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        capture();
        chk({name, "_d3"}, cap_seg[3] === e3, cap_seg[3], e3);
        chk({name, "_d2"}, cap_seg[2] === e2, cap_seg[2], e2);
        chk({name, "_d1"}, cap_seg[1] === e1, cap_seg[1], e1);
        chk({name, "_d0"}, cap_seg[0] === e0, cap_seg[0], e0);
    endtask

    // Counts busy-high negedges after a load, bounded so a stuck busy cannot hang the run.
    task automatic wait_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [3:0] exp_an;
        reset = 1'b1; value = '0; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;

        repeat (3) @(negedge clk);
        chk("rst_anode", anode_n === 4'b1111, anode_n, 4'b1111);
        chk("rst_seg", seg_n === 7'b1111111, seg_n, 7'b1111111);
        chk("rst_dp", dp_n === 1'b1, dp_n, 1'b1);
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_ovf", overflow === 1'b0, overflow, 1'b0);

        // Scan order and dwell after release; digit 0 appears on the first edge.
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
            chk($sformatf("scan_anode_%0d", k), anode_n === exp_an, anode_n, exp_an);
            chk($sformatf("scan_seg_%0d", k), seg_n === S0, seg_n, S0);
        end

        do_load(16'hBEEF, 1'b0);
        @(negedge clk);
        chk("hex_busy_after_load", busy === 1'b0, busy, 1'b0);
        check_digits("hex_beef", SB, SE, SE, SF);
        chk("hex_busy_seen", busy_seen === 1'b0, busy_seen, 1'b0);
        chk("hex_ovf", overflow === 1'b0, overflow, 1'b0);

        do_load(16'd1234, 1'b1);
        wait_busy(n);
        chk("dec1234_busy_cycles", n == 17, n, 17);
        check_digits("dec1234", S1, S2, S3, S4);
        chk("dec1234_ovf", overflow === 1'b0, overflow, 1'b0);

        blank_lz = 1'b1;
        do_load(16'd42, 1'b1);
        wait_busy(n);
        chk("dec42_busy_cycles", n == 17, n, 17);
        check_digits("dec42_lz", SBLK, SBLK, S4, S2);

        do_load(16'd0, 1'b1);
        wait_busy(n);
        check_digits("dec0_lz", SBLK, SBLK, SBLK, S0);

        do_load(16'd12345, 1'b1);
        wait_busy(n);
        chk("dec12345_busy_cycles", n == 17, n, 17);
        chk("dec12345_ovf", overflow === 1'b1, overflow, 1'b1);
        check_digits("dec12345", SDASH, SDASH, SDASH, SDASH);

        // A second strobe while converting must be dropped.
        blank_lz = 1'b0;
        do_load(16'd5678, 1'b1);
        repeat (3) @(posedge clk);
        do_load(16'd9999, 1'b1);
        wait_busy(n);
        chk("second_load_ovf", overflow === 1'b0, overflow, 1'b0);
        check_digits("second_load", S5, S6, S7, S8);
        chk("second_load_busy_after", busy === 1'b0, busy, 1'b0);

        // Reset clears the display; a conversion cut by reset must never commit.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        do_load(16'd1234, 1'b1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midshift_rst_busy", busy === 1'b0, busy, 1'b0);
        chk("midshift_rst_anode", anode_n === 4'b1111, anode_n, 4'b1111);
        @(posedge clk);
        #1 reset = 1'b0;
        dp_mask = 4'b0100;
        repeat (30) @(posedge clk);
        chk("midshift_busy_after", busy === 1'b0, busy, 1'b0);
        check_digits("midshift_disp", S0, S0, S0, S0);
        chk("dp_d3", cap_dp[3] === 1'b1, cap_dp[3], 1'b1);
        chk("dp_d2", cap_dp[2] === 1'b0, cap_dp[2], 1'b0);
        chk("dp_d1", cap_dp[1] === 1'b1, cap_dp[1], 1'b1);
        chk("dp_d0", cap_dp[0] === 1'b1, cap_dp[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
